deconv_2d: RTL and testbench
============================

Name: deconv_2d

Overview:
Streaming 2-D transposed convolution (deconvolution) engine. A K×K kernel and an N×N unsigned image are loaded serially, one pixel per cycle. On `enable`, each input pixel scales the whole kernel, and the product patch is scatter-accumulated into an (N*K)×(N*K) output map at offset (row*STRIDE, col*STRIDE). Used as an upsampling stage between pixel-stream producers and a consumer reading the parallel output map.

Parameters:
- N, default 2: input image side length; input pixels = N*N.
- K, default 3: kernel side length; kernel weights = K*K.
- PIXEL_WIDTH, default 8: width of image, kernel and output pixels (unsigned).
- STRIDE, default 2: output step between neighbouring input pixels.
- ACCUM_WIDTH (localparam), = 2*PIXEL_WIDTH + $clog2(N*N+1): width of each output accumulator.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  start pulse; honoured only in IDLE with both buffers loaded.
- load_kernel  in  1  kernel stream valid.
- load_input  in  1  image stream valid.
- image_input  in  PIXEL_WIDTH  image pixel, row-major.
- kernel_input  in  PIXEL_WIDTH  kernel weight, row-major.
- input_ready  out  1  image buffer can accept a pixel.
- kernel_ready  out  1  kernel buffer can accept a weight.
- done  out  1  result valid.
- image_output  out  unpacked array [0:N*K*N*K-1] of PIXEL_WIDTH  output map, row-major, row stride N*K.

Behaviour:
- Reset (async, any time, including mid-run):
  - FSM to IDLE; all counters, buffers and accumulators cleared.
  - kernel_loaded=0, input_loaded=0, done=0, image_output all 0.
  - kernel_ready=1 and input_ready=1 from the first clock after reset deassert.
- Kernel load:
  - Each rising edge with load_kernel && kernel_ready stores kernel_input into kernel_weights[count] and increments count.
  - The edge accepting weight K*K-1 sets kernel_loaded=1.
  - kernel_ready = !kernel_loaded.
  - load_kernel while kernel_ready=0 is ignored.
  - Weights persist until rst.
- Image load: identical mechanism with load_input, image[], input_loaded and input_ready; N*N pixels.
- Loading the two buffers in either order, or concurrently, is legal.
- deconv_state (2 bits):
  - IDLE=00: enable && kernel_loaded && input_loaded -> clear accumulators, input_select=0, done=0, go RECIEVE. enable otherwise ignored.
  - RECIEVE=01: input_pix <= image[input_select]; go MULTIPLY.
  - MULTIPLY=10: prod[k] <= input_pix*kernel_weights[k] for all k in 0..K*K-1 in parallel, 2*PIXEL_WIDTH bits each; decode_done pulses; go ACCUMULATE.
  - ACCUMULATE=11: accum_enable=1. With r=input_select/N, c=input_select%N, kr=k/K, kc=k%K, add prod[k] into accum_out[(r*STRIDE+kr)*(N*K)+(c*STRIDE+kc)].
    - Contributions whose row or column is >= N*K are discarded.
    - If input_select==N*N-1: done<=1, go IDLE. Else input_select++, go RECIEVE.
- Latency: 3 cycles per input pixel; done rises 3*N*N cycles after the accepting enable edge (12 for defaults).
- done stays high until the next accepted enable or rst. A re-run with the same buffers is allowed.
- image_output[i] = accum_out[i] saturated to 2^PIXEL_WIDTH-1, driven combinationally from the accumulators. Stable while done=1.
- Unwritten output positions read 0. With defaults, row 5 and column 5 are always 0.
- Internal names kernel_loaded, input_loaded, deconv_state, input_select, input_pix, image, kernel_weights, prod, decoded_image, decode_done, accum_enable and accum_out must exist for hierarchical probing.

Test Plan:
- Reset, then identity-diagonal kernel [1,0,0;0,1,0;0,0,1], image [1,2;3,4], then enable pulse. Required:
  - done within 12 cycles.
  - Non-zero pixels exactly: (0,0)=1, (1,1)=1, (2,2)=5, (0,2)=2, (1,3)=2, (2,4)=2, (2,0)=3, (3,1)=3, (4,2)=3, (3,3)=4, (4,4)=4.
  - All other pixels 0; total sum 30.
- During loading: kernel_ready drops on the edge after the 9th weight and kernel_loaded=1; input_ready drops after the 4th pixel. Extra load pulses leave buffers unchanged.
- enable with only the kernel loaded -> FSM stays IDLE, done stays 0. After the image load completes, enable runs normally.
- All-ones kernel, image [255,255;255,255] -> overlapped pixel (2,2) accumulates 1020 and saturates to 255; corner (0,0)=255.
- Assert rst during MULTIPLY -> done=0, outputs 0, both ready signals 1. Reload both buffers and rerun -> identical result to the first scenario.
- Second enable after done with unchanged buffers -> done drops, then rises after 12 cycles with the same map; accumulators do not double.

Source files
------------

// File: rtl/deconv_2d.sv
// Streaming 2-D transposed convolution. The kernel and image load serially. Each image pixel then
// runs RECIEVE/MULTIPLY/ACCUMULATE to scatter-add a scaled copy of the kernel into the output map.
module deconv_2d #(
    parameter int N           = 2,
    parameter int K           = 3,
    parameter int PIXEL_WIDTH = 8,
    parameter int STRIDE      = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   load_kernel,
    input  logic                   load_input,
    input  logic [PIXEL_WIDTH-1:0] image_input,
    input  logic [PIXEL_WIDTH-1:0] kernel_input,
    output logic                   input_ready,
    output logic                   kernel_ready,
    output logic                   done,
    output logic [PIXEL_WIDTH-1:0] image_output [0:N*K*N*K-1]
);
    localparam int ACCUM_WIDTH = 2*PIXEL_WIDTH + $clog2(N*N+1);
    localparam int NN          = N*N;
    localparam int KK          = K*K;
    localparam int NK          = N*K;
    localparam int OUT_PIX     = NK*NK;
    localparam int PROD_W      = 2*PIXEL_WIDTH;
    localparam int SEL_W       = (NN > 1) ? $clog2(NN) : 1;
    localparam int KSEL_W      = (KK > 1) ? $clog2(KK) : 1;
    localparam logic [ACCUM_WIDTH-1:0] SAT_MAX =
        {{(ACCUM_WIDTH-PIXEL_WIDTH){1'b0}}, {PIXEL_WIDTH{1'b1}}};

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        RECIEVE    = 2'b01,
        MULTIPLY   = 2'b10,
        ACCUMULATE = 2'b11
    } state_t;

    state_t deconv_state;
    state_t w_next_state;

    logic                   kernel_loaded;
    logic                   input_loaded;
    logic [KSEL_W-1:0]      r_kernel_count;
    logic [SEL_W-1:0]       r_input_count;
    logic [SEL_W-1:0]       input_select;
    logic [PIXEL_WIDTH-1:0] input_pix;
    logic [PIXEL_WIDTH-1:0] image          [0:NN-1];
    logic [PIXEL_WIDTH-1:0] kernel_weights [0:KK-1];
    logic [PROD_W-1:0]      prod           [0:KK-1];
    logic [ACCUM_WIDTH-1:0] accum_out      [0:OUT_PIX-1];
    logic [ACCUM_WIDTH-1:0] w_accum_next   [0:OUT_PIX-1];
    logic [PIXEL_WIDTH-1:0] decoded_image  [0:OUT_PIX-1];
    logic                   decode_done;
    logic                   accum_enable;
    logic                   w_start;
    logic                   w_last_pixel;
    int                     w_row_base;
    int                     w_col_base;

    assign kernel_ready = !kernel_loaded;
    assign input_ready  = !input_loaded;
    assign w_start      = enable && kernel_loaded && input_loaded;
    assign w_last_pixel = (input_select == SEL_W'(NN-1));
    assign decode_done  = (deconv_state == MULTIPLY);
    assign accum_enable = (deconv_state == ACCUMULATE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kernel_loaded  <= 1'b0;
            r_kernel_count <= '0;
            for (int k = 0; k < KK; k++) kernel_weights[k] <= '0;
        end else if (load_kernel && kernel_ready) begin
            kernel_weights[r_kernel_count] <= kernel_input;
            if (r_kernel_count == KSEL_W'(KK-1))
                kernel_loaded <= 1'b1;
            else
                r_kernel_count <= r_kernel_count + KSEL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            input_loaded  <= 1'b0;
            r_input_count <= '0;
            for (int i = 0; i < NN; i++) image[i] <= '0;
        end else if (load_input && input_ready) begin
            image[r_input_count] <= image_input;
            if (r_input_count == SEL_W'(NN-1))
                input_loaded <= 1'b1;
            else
                r_input_count <= r_input_count + SEL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            deconv_state <= IDLE;
        else
            deconv_state <= w_next_state;
    end

    always_comb begin
        w_next_state = deconv_state;
        case (deconv_state)
            IDLE:       if (w_start) w_next_state = RECIEVE;
            RECIEVE:    w_next_state = MULTIPLY;
            MULTIPLY:   w_next_state = ACCUMULATE;
            ACCUMULATE: w_next_state = w_last_pixel ? IDLE : RECIEVE;
            default:    w_next_state = IDLE;
        endcase
    end

    // Gather form of the scatter: each output position picks the one kernel tap (if any) that
    // lands on it for the current pixel, so taps falling past the map edge simply match nothing.
    always_comb begin
        w_row_base = (int'(input_select) / N) * STRIDE;
        w_col_base = (int'(input_select) % N) * STRIDE;
        for (int p = 0; p < OUT_PIX; p++) begin
            w_accum_next[p] = accum_out[p];
            for (int k = 0; k < KK; k++) begin
                if ((w_row_base + k / K == p / NK) && (w_col_base + k % K == p % NK))
                    w_accum_next[p] = w_accum_next[p] + ACCUM_WIDTH'(prod[k]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done         <= 1'b0;
            input_select <= '0;
            input_pix    <= '0;
            for (int k = 0; k < KK; k++) prod[k] <= '0;
            for (int p = 0; p < OUT_PIX; p++) accum_out[p] <= '0;
        end else if (deconv_state == IDLE) begin
            if (w_start) begin
                done         <= 1'b0;
                input_select <= '0;
                for (int p = 0; p < OUT_PIX; p++) accum_out[p] <= '0;
            end
        end else if (deconv_state == RECIEVE) begin
            input_pix <= image[input_select];
        end else if (decode_done) begin
            for (int k = 0; k < KK; k++) prod[k] <= input_pix * kernel_weights[k];
        end else if (accum_enable) begin
            for (int p = 0; p < OUT_PIX; p++) accum_out[p] <= w_accum_next[p];
            if (w_last_pixel)
                done <= 1'b1;
            else
                input_select <= input_select + SEL_W'(1);
        end
    end

    always_comb begin
        for (int p = 0; p < OUT_PIX; p++) begin
            decoded_image[p] = (accum_out[p] > SAT_MAX) ? SAT_MAX[PIXEL_WIDTH-1:0]
                                                        : accum_out[p][PIXEL_WIDTH-1:0];
            image_output[p]  = decoded_image[p];
        end
    end

endmodule

// File: tb/tb_deconv_2d.sv
// Scoreboarded bench for deconv_2d: the stimulus pushes reference maps and the monitor compares
// them on each rising edge of done.
module tb_deconv_2d;
    localparam int N       = 2;
    localparam int K       = 3;
    localparam int PW      = 8;
    localparam int STRIDE  = 2;
    localparam int NN      = N*N;
    localparam int KK      = K*K;
    localparam int NK      = N*K;
    localparam int OUTP    = NK*NK;
    localparam int MAPW    = OUTP*PW;
    localparam int LATENCY = 3*NN;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          load_kernel = 1'b0;
    logic          load_input = 1'b0;
    logic [PW-1:0] image_input = '0;
    logic [PW-1:0] kernel_input = '0;
    logic          input_ready;
    logic          kernel_ready;
    logic          done;
    logic [PW-1:0] image_output [0:OUTP-1];

    deconv_2d #(.N(N), .K(K), .PIXEL_WIDTH(PW), .STRIDE(STRIDE)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .load_kernel  (load_kernel),
        .load_input   (load_input),
        .image_input  (image_input),
        .kernel_input (kernel_input),
        .input_ready  (input_ready),
        .kernel_ready (kernel_ready),
        .done         (done),
        .image_output (image_output)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int kerArr [KK];
    int imgArr [NN];
    logic [MAPW-1:0] expQ[$];
    int acceptQ[$];
    logic prevDone = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference: every input pixel stamps a scaled kernel at (r*STRIDE, c*STRIDE), then saturate.
    function automatic logic [MAPW-1:0] modelMap();
        int acc [OUTP];
        logic [MAPW-1:0] m;
        int orow, ocol;
        foreach (acc[i]) acc[i] = 0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                for (int kr = 0; kr < K; kr++)
                    for (int kc = 0; kc < K; kc++) begin
                        orow = r*STRIDE + kr;
                        ocol = c*STRIDE + kc;
                        if (orow < NK && ocol < NK)
                            acc[orow*NK + ocol] += imgArr[r*N + c] * kerArr[kr*K + kc];
                    end
        m = '0;
        for (int i = 0; i < OUTP; i++)
            m[i*PW +: PW] = (acc[i] > (1 << PW) - 1) ? {PW{1'b1}} : PW'(acc[i]);
        return m;
    endfunction

    function automatic int sumOutputs();
        int s = 0;
        for (int i = 0; i < OUTP; i++) s += int'(image_output[i]);
        return s;
    endfunction

    always @(negedge clk) begin
        logic [MAPW-1:0] e;
        int a;
        if (!rst && done && !prevDone) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedDone: got done=1, expected no completion");
            end else begin
                e = expQ.pop_front();
                a = acceptQ.pop_front();
                checkOutput("doneLatency", cycle - a, LATENCY);
                for (int i = 0; i < OUTP; i++)
                    checkOutput($sformatf("pix_r%0d_c%0d", i / NK, i % NK),
                                int'(image_output[i]), int'(e[i*PW +: PW]));
            end
        end
        prevDone = done;
    end

    task automatic assertReset();
        rst = 1'b1;
        enable = 1'b0;
        load_kernel = 1'b0;
        load_input = 1'b0;
        #1;
        expQ.delete();
        acceptQ.delete();
    endtask

    task automatic releaseReset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic loadBuffers(input bit doKernel, input bit doImage, input bit randomGaps);
        int kIdx = 0;
        int iIdx = 0;
        int guard = 0;
        while (((doKernel && kIdx < KK) || (doImage && iIdx < NN)) && guard < 300) begin
            load_kernel  = doKernel && kIdx < KK && (!randomGaps || $urandom_range(1, 0) == 1);
            load_input   = doImage && iIdx < NN && (!randomGaps || $urandom_range(1, 0) == 1);
            kernel_input = PW'(kerArr[(kIdx < KK) ? kIdx : 0]);
            image_input  = PW'(imgArr[(iIdx < NN) ? iIdx : 0]);
            if (load_kernel) checkOutput("kernelReadyDuringLoad", int'(kernel_ready), 1);
            if (load_input)  checkOutput("inputReadyDuringLoad", int'(input_ready), 1);
            @(posedge clk);
            if (load_kernel) kIdx++;
            if (load_input) iIdx++;
            @(negedge clk);
            guard++;
        end
        load_kernel = 1'b0;
        load_input  = 1'b0;
        if (guard >= 300) checkOutput("loadTimeout", guard, 0);
    endtask

    task automatic applyStimulus(input bit expectRun);
        enable = 1'b1;
        if (expectRun) begin
            expQ.push_back(modelMap());
            acceptQ.push_back(cycle + 1);
        end
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic waitDone(input string name);
        int n = 0;
        while (!done && n < LATENCY + 8) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, int'(done), 1);
        @(negedge clk);
    endtask

    task automatic setIdentityScenario();
        for (int k = 0; k < KK; k++) kerArr[k] = (k / K == k % K) ? 1 : 0;
        for (int i = 0; i < NN; i++) imgArr[i] = i + 1;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        assertReset();
        checkOutput("resetDone", int'(done), 0);
        checkOutput("resetSum", sumOutputs(), 0);
        releaseReset();
        checkOutput("resetKernelReady", int'(kernel_ready), 1);
        checkOutput("resetInputReady", int'(input_ready), 1);
        checkOutput("resetState", int'(dut.deconv_state), 0);

        // Kernel only, then an early enable that must be ignored.
        setIdentityScenario();
        loadBuffers(1'b1, 1'b0, 1'b0);
        checkOutput("kernelReadyAfterLoad", int'(kernel_ready), 0);
        checkOutput("kernelLoaded", int'(dut.kernel_loaded), 1);
        load_kernel = 1'b1;
        kernel_input = 8'hAA;
        repeat (2) @(negedge clk);
        load_kernel = 1'b0;
        for (int k = 0; k < KK; k++)
            checkOutput($sformatf("kernelKept%0d", k), int'(dut.kernel_weights[k]), kerArr[k]);
        applyStimulus(1'b0);
        repeat (3) begin
            checkOutput("idleWithoutImage", int'(dut.deconv_state), 0);
            checkOutput("doneWithoutImage", int'(done), 0);
            @(negedge clk);
        end

        loadBuffers(1'b0, 1'b1, 1'b0);
        checkOutput("inputReadyAfterLoad", int'(input_ready), 0);
        load_input = 1'b1;
        image_input = 8'h55;
        repeat (2) @(negedge clk);
        load_input = 1'b0;
        for (int i = 0; i < NN; i++)
            checkOutput($sformatf("imageKept%0d", i), int'(dut.image[i]), imgArr[i]);

        applyStimulus(1'b1);
        waitDone("identityDone");
        checkOutput("identityPix22", int'(image_output[2*NK + 2]), 5);
        checkOutput("identityPix24", int'(image_output[2*NK + 4]), 2);
        checkOutput("identitySum", sumOutputs(), 30);
        checkOutput("identityRow5", int'(image_output[5*NK + 3]), 0);

        // Re-run with unchanged buffers: done must drop and the map must not double.
        applyStimulus(1'b1);
        checkOutput("rerunDoneDrops", int'(done), 0);
        waitDone("rerunDone");
        checkOutput("rerunSum", sumOutputs(), 30);

        // Reset in the middle of a run.
        applyStimulus(1'b1);
        for (int n = 0; n < 5 && dut.deconv_state != 2'b10; n++) @(negedge clk);
        checkOutput("reachedMultiply", int'(dut.deconv_state), 2);
        assertReset();
        checkOutput("midResetDone", int'(done), 0);
        checkOutput("midResetSum", sumOutputs(), 0);
        checkOutput("midResetKernelReady", int'(kernel_ready), 1);
        checkOutput("midResetInputReady", int'(input_ready), 1);
        checkOutput("midResetState", int'(dut.deconv_state), 0);
        releaseReset();
        loadBuffers(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1);
        waitDone("reloadDone");
        checkOutput("reloadSum", sumOutputs(), 30);

        // Saturation on overlapping taps.
        assertReset();
        releaseReset();
        for (int k = 0; k < KK; k++) kerArr[k] = 1;
        for (int i = 0; i < NN; i++) imgArr[i] = 255;
        loadBuffers(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1);
        waitDone("saturateDone");
        checkOutput("saturateAccum22", int'(dut.accum_out[2*NK + 2]), 1020);
        checkOutput("saturatePix22", int'(image_output[2*NK + 2]), 255);
        checkOutput("saturatePix00", int'(image_output[0]), 255);

        // Random buffers with interleaved loading.
        for (int round = 0; round < 6; round++) begin
            assertReset();
            releaseReset();
            for (int k = 0; k < KK; k++)
                kerArr[k] = (round % 2 == 0) ? int'($urandom_range(15, 0)) : int'($urandom_range(255, 0));
            for (int i = 0; i < NN; i++)
                imgArr[i] = (round % 2 == 0) ? int'($urandom_range(15, 0)) : int'($urandom_range(255, 0));
            loadBuffers(1'b1, 1'b1, 1'b1);
            applyStimulus(1'b1);
            waitDone($sformatf("randomDone%0d", round));
            if (round == 3) begin
                applyStimulus(1'b1);
                waitDone("randomRerunDone");
            end
        end

        repeat (2) @(negedge clk);
        checkOutput("scoreboardDrained", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
